// File: rtl/clause_literal_streamer.sv
// Clause literal streamer: stores a zero-terminated CNF literal list and, per
// pass, streams every literal with a "survives reduction" flag under a
// snapshot of the partial assignment, plus an empty-clause conflict flag.
module clause_literal_streamer #(
    parameter int WIDTH    = 4,
    parameter int NUM_VARS = 16,
    parameter int MAX_LITS = 64,
    parameter int CNT_W    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load_valid,
    input  logic [WIDTH:0]      load_literal,
    output logic                load_ready,
    input  logic                start,
    input  logic [NUM_VARS-1:0] assign_set,
    input  logic [NUM_VARS-1:0] assign_val,
    output logic                busy,
    output logic [WIDTH:0]      literal_out,
    output logic                literal_valid,
    output logic                literal_in_reduced_form,
    output logic                inputs_over,
    output logic                conflict,
    output logic [CNT_W-1:0]    lit_count
);
    localparam int AW = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH:0]      mem [0:MAX_LITS-1];
    logic [CNT_W-1:0]    ptr, clause_start, clause_end;
    logic [CNT_W-1:0]    ptr_inc, end_inc;
    logic                clause_sat, has_free;
    logic [NUM_VARS-1:0] snap_set, snap_val;

    logic [WIDTH:0]      cur_lit;
    logic [WIDTH-1:0]    cur_var;
    logic                cur_neg, cur_zero, cur_true, cur_free;
    logic                sat_acc, free_acc;
    logic                scan_at_end, scan_last, scan_empty, emit_last;
    logic                load_fire;

    // Literal decode at the current pointer against the assignment snapshot.
    assign cur_lit   = mem[ptr[AW-1:0]];
    assign cur_neg   = cur_lit[WIDTH];
    assign cur_zero  = (cur_lit == '0);
    assign cur_var   = cur_neg ? (~cur_lit[WIDTH-1:0] + 1'b1) : cur_lit[WIDTH-1:0];
    assign cur_true  = !cur_zero && snap_set[cur_var] && (snap_val[cur_var] == !cur_neg);
    assign cur_free  = !cur_zero && !snap_set[cur_var];
    assign sat_acc   = clause_sat | cur_true;
    assign free_acc  = has_free | cur_free;

    assign ptr_inc     = ptr + 1'b1;
    assign end_inc     = clause_end + 1'b1;
    // ptr == lit_count in SCAN only happens on an empty store.
    assign scan_at_end = (ptr >= lit_count);
    // The last stored literal doubles as an implicit terminator.
    assign scan_last   = cur_zero || (ptr_inc == lit_count);
    assign scan_empty  = cur_zero && (ptr == clause_start);
    assign emit_last   = (ptr_inc == clause_end);

    assign load_ready = (state == IDLE) && !clear && !start && (lit_count < CNT_W'(MAX_LITS));
    assign load_fire  = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !clear) state_nx = SCAN;
            SCAN: begin
                if (scan_at_end)
                    state_nx = DONE;
                else if (scan_last) begin
                    if (scan_empty) state_nx = (ptr_inc >= lit_count) ? DONE : SCAN;
                    else            state_nx = EMIT;
                end
            end
            EMIT: if (emit_last) state_nx = (end_inc >= lit_count) ? DONE : SCAN;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy        = (state != IDLE);
        inputs_over = (state == DONE);
    end

    // Literal store write port; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (!reset && load_fire) mem[lit_count[AW-1:0]] <= load_literal;
    end

    // Pass datapath: pointers, clause accumulators, conflict, registered stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            lit_count               <= '0;
            ptr                     <= '0;
            clause_start            <= '0;
            clause_end              <= '0;
            clause_sat              <= 1'b0;
            has_free                <= 1'b0;
            snap_set                <= '0;
            snap_val                <= '0;
            conflict                <= 1'b0;
            literal_out             <= '0;
            literal_valid           <= 1'b0;
            literal_in_reduced_form <= 1'b0;
        end else begin
            literal_out             <= '0;
            literal_valid           <= 1'b0;
            literal_in_reduced_form <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear)
                        lit_count <= '0;
                    else if (start) begin
                        snap_set     <= assign_set;
                        snap_val     <= assign_val;
                        conflict     <= 1'b0;
                        ptr          <= '0;
                        clause_start <= '0;
                        clause_sat   <= 1'b0;
                        has_free     <= 1'b0;
                    end else if (load_fire)
                        lit_count <= lit_count + 1'b1;
                end
                SCAN: begin
                    if (!scan_at_end) begin
                        if (!scan_last) begin
                            clause_sat <= sat_acc;
                            has_free   <= free_acc;
                            ptr        <= ptr_inc;
                        end else if (scan_empty) begin
                            // Nothing to emit: an empty clause is a conflict outright.
                            conflict     <= 1'b1;
                            ptr          <= ptr_inc;
                            clause_start <= ptr_inc;
                        end else begin
                            clause_sat <= sat_acc;
                            has_free   <= free_acc;
                            clause_end <= cur_zero ? ptr : ptr_inc;
                            ptr        <= clause_start;
                        end
                    end
                end
                EMIT: begin
                    literal_valid           <= 1'b1;
                    literal_out             <= cur_lit;
                    literal_in_reduced_form <= !clause_sat && cur_free;
                    if (emit_last) begin
                        if (!clause_sat && !has_free) conflict <= 1'b1;
                        ptr          <= end_inc;
                        clause_start <= end_inc;
                        clause_sat   <= 1'b0;
                        has_free     <= 1'b0;
                    end else
                        ptr <= ptr_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_literal_streamer.sv
// Scoreboard bench for clause_literal_streamer: stimulus pushes expected
// (literal, flag) pairs and conflict values; a negedge monitor pops and compares.
module tb_clause_literal_streamer;
    localparam int WIDTH = 4, NUM_VARS = 16, MAX_LITS = 64, CNT_W = 7;

    logic                clk = 1'b0, reset = 1'b1, clear = 1'b0;
    logic                load_valid = 1'b0, start = 1'b0;
    logic [WIDTH:0]      load_literal = '0;
    logic [NUM_VARS-1:0] assign_set = '0, assign_val = '0;
    logic                load_ready, busy, literal_valid, rf, inputs_over, conflict;
    logic [WIDTH:0]      literal_out;
    logic [CNT_W-1:0]    lit_count;

    clause_literal_streamer #(.WIDTH(WIDTH), .NUM_VARS(NUM_VARS), .MAX_LITS(MAX_LITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_literal(load_literal), .load_ready(load_ready), .start(start),
        .assign_set(assign_set), .assign_val(assign_val), .busy(busy),
        .literal_out(literal_out), .literal_valid(literal_valid),
        .literal_in_reduced_form(rf), .inputs_over(inputs_over),
        .conflict(conflict), .lit_count(lit_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, io_count = 0;
    logic [WIDTH+1:0] sb[$];
    logic             conf_q[$];
    logic [WIDTH+1:0] mon_e;
    int               vec[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lit, input bit f);
        sb.push_back({lit[WIDTH:0], f});
    endtask

    // Monitor: compare every emitted literal and every end-of-pass conflict.
    always @(negedge clk) begin
        if (literal_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL stream: unexpected literal %0d, none expected", literal_out);
            end else begin
                mon_e = sb.pop_front();
                chk("literal_out", 32'(literal_out), 32'(mon_e[WIDTH+1:1]));
                chk("reduced_flag", 32'(rf), 32'(mon_e[0]));
            end
        end
        if (inputs_over === 1'b1) begin
            io_count++;
            if (conf_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL inputs_over: unexpected pulse, none expected");
            end else
                chk("conflict", 32'(conflict), 32'(conf_q.pop_front()));
        end
    end

    task automatic load_lit(input int v);
        load_valid = 1'b1; load_literal = v[WIDTH:0];
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic load_vec();
        foreach (vec[i]) load_lit(vec[i]);
    endtask

    task automatic clear_store();
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        chk("clear_count", 32'(lit_count), 0);
    endtask

    // Start a pass; count cycles from the start edge to the inputs_over pulse.
    task automatic run_pass(input int exp_cyc, input bit exp_conf, input bit disturb);
        int n, io0;
        conf_q.push_back(exp_conf);
        io0 = io_count;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (disturb && n == 4) begin
                assign_val = ~assign_val; assign_set = ~assign_set; start = 1'b1;
            end
            if (disturb && n == 5) start = 1'b0;
        end while (inputs_over !== 1'b1 && n < 200);
        chk("io_cycles", 32'(n), 32'(exp_cyc));
        repeat (4) @(posedge clk); #1;
        chk("io_once", 32'(io_count - io0), 1);
        chk("sb_drained", 32'(sb.size()), 0);
        chk("idle_after", 32'(busy), 0);
        sb.delete(); conf_q.delete();
    endtask

    initial begin
        int io0;
        // Reset state
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(lit_count), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_valid", 32'(literal_valid), 0);
        chk("rst_io", 32'(inputs_over), 0);
        chk("rst_conflict", 32'(conflict), 0);

        // Three 2-literal clauses, x1=1
        vec = '{1, -2, 0, 2, 3, 0, -1, 4, 0};
        load_vec();
        chk("t1_count", 32'(lit_count), 9);
        assign_set = 16'h0002; assign_val = 16'h0002;
        push_exp(1, 0); push_exp(-2, 0); push_exp(2, 1); push_exp(3, 1); push_exp(-1, 0); push_exp(4, 1);
        run_pass(16, 0, 0);
        // Same pass with inputs changed and start re-pulsed mid-pass
        assign_set = 16'h0002; assign_val = 16'h0002;
        push_exp(1, 0); push_exp(-2, 0); push_exp(2, 1); push_exp(3, 1); push_exp(-1, 0); push_exp(4, 1);
        run_pass(16, 0, 1);

        // Fully falsified clause -> conflict
        clear_store();
        vec = '{1, 2, 0};
        load_vec();
        assign_set = 16'h0006; assign_val = 16'h0000;
        push_exp(1, 0); push_exp(2, 0);
        run_pass(6, 1, 0);
        chk("conflict_held", 32'(conflict), 1);

        // Empty store: straight to DONE, conflict cleared
        clear_store();
        run_pass(2, 0, 0);

        // No final terminator, nothing assigned
        vec = '{3, -3};
        load_vec();
        assign_set = '0; assign_val = '0;
        push_exp(3, 1); push_exp(-3, 1);
        run_pass(5, 0, 0);

        // Single empty clause
        clear_store();
        load_lit(0);
        run_pass(2, 1, 0);

        // Clause then consecutive terminators (empty clause)
        clear_store();
        vec = '{1, 0, 0};
        load_vec();
        push_exp(1, 1);
        run_pass(5, 1, 0);

        // Reset during EMIT aborts the pass
        clear_store();
        vec = '{1, 2, 0};
        load_vec();
        push_exp(1, 1);
        io0 = io_count;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(literal_valid), 0);
        chk("abort_count", 32'(lit_count), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("abort_no_io", 32'(io_count - io0), 0);
        chk("abort_sb", 32'(sb.size()), 0);
        sb.delete();

        // Fill the store, overflow attempt, then clear+start together
        for (int i = 0; i < MAX_LITS; i++) load_lit((i % 5) + 1);
        chk("full_count", 32'(lit_count), 64);
        chk("full_ready", 32'(load_ready), 0);
        load_lit(7);
        chk("full_drop", 32'(lit_count), 64);
        io0 = io_count;
        clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        chk("clrstart_count", 32'(lit_count), 0);
        repeat (3) @(posedge clk); #1;
        chk("clrstart_busy", 32'(busy), 0);
        chk("clrstart_no_io", 32'(io_count - io0), 0);
        chk("clrstart_ready", 32'(load_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
